// File: rtl/clk_div_ctrl.sv
// Glitch-safe sequencer for the ClkDiv ratio/enable inputs.
// Optional range check on requested ratios: define CLK_DIV_CTRL_RANGE_CHK_EN.
//
// state  | meaning
// IDLE   | ready for a request; no-op/reject pulses issued from here
// DRAIN  | divider gated, waiting 2*ratio+DRAIN_EXTRA cycles for it to quiesce
// LOAD   | drive the new ratio (or finish if the request was a disable)
// SETTLE | new ratio applied, waiting SETTLE_CYCLES before re-enabling
module clk_div_ctrl #(
  parameter int RATIO_W       = 3,
  parameter int DEF_RATIO     = 2,
  parameter int DRAIN_EXTRA   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  input  logic [RATIO_W-1:0] i_req_ratio,
  input  logic               i_req_en,
  output logic               o_req_ready,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_clk_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int CNT_W = RATIO_W + 2;
  localparam logic [CNT_W-1:0] DRAIN_ADD = CNT_W'(DRAIN_EXTRA - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [RATIO_W-1:0] lat_ratio_q, lat_ratio_d;
  logic               lat_en_q, lat_en_d;
  logic               clk_en_q, clk_en_d;
  logic               done_q, done_d;
  logic               noop_pend_q, noop_pend_d;
  logic               accept, is_noop, reject;
  logic [CNT_W-1:0]   drain_ld;

  assign accept   = i_req_valid && (state_q == IDLE);
  assign is_noop  = (i_req_ratio == ratio_q) && (i_req_en == clk_en_q);
  // 2*ratio fits without a multiplier: shift into the wider counter width
  assign drain_ld = {1'b0, ratio_q, 1'b0} + DRAIN_ADD;

`ifdef CLK_DIV_CTRL_RANGE_CHK_EN
  logic err_q, err_d, rej_pend_q, rej_pend_d;
  assign reject = i_req_en && (i_req_ratio < RATIO_W'(2));
  assign o_err  = err_q;
`else
  assign reject = 1'b0;
  assign o_err  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    clk_en_d    = clk_en_q;
    lat_ratio_d = lat_ratio_q;
    lat_en_d    = lat_en_q;
    done_d      = noop_pend_q;
    noop_pend_d = 1'b0;
`ifdef CLK_DIV_CTRL_RANGE_CHK_EN
    err_d       = rej_pend_q;
    rej_pend_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          lat_ratio_d = i_req_ratio;
          lat_en_d    = i_req_en;
          if (reject) begin
`ifdef CLK_DIV_CTRL_RANGE_CHK_EN
            rej_pend_d = 1'b1;
`endif
          end else if (is_noop) begin
            noop_pend_d = 1'b1;
          end else if (clk_en_q) begin
            clk_en_d = 1'b0;
            cnt_d    = drain_ld;
            state_d  = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      LOAD: begin
        if (lat_en_q) begin
          ratio_d = lat_ratio_q;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          clk_en_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ratio_q     <= RATIO_W'(DEF_RATIO);
      clk_en_q    <= 1'b0;
      lat_ratio_q <= '0;
      lat_en_q    <= 1'b0;
      done_q      <= 1'b0;
      noop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      clk_en_q    <= clk_en_d;
      lat_ratio_q <= lat_ratio_d;
      lat_en_q    <= lat_en_d;
      done_q      <= done_d;
      noop_pend_q <= noop_pend_d;
    end
  end

`ifdef CLK_DIV_CTRL_RANGE_CHK_EN
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q      <= 1'b0;
      rej_pend_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      rej_pend_q <= rej_pend_d;
    end
  end
`endif

  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_div_ratio = ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: driver queues expected done/err pulses,
// a negedge monitor pops and compares them.
module tb_clk_div_ctrl;

  logic       i_ref_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_req_valid = 1'b0;
  logic [2:0] i_req_ratio = 3'd0;
  logic       i_req_en = 1'b0;
  logic       o_req_ready, o_clk_en, o_busy, o_done, o_err;
  logic [2:0] o_div_ratio;

  clk_div_ctrl dut (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_req_valid(i_req_valid),
    .i_req_ratio(i_req_ratio),
    .i_req_en   (i_req_en),
    .o_req_ready(o_req_ready),
    .o_div_ratio(o_div_ratio),
    .o_clk_en   (o_clk_en),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  int cyc = 0;
  always @(posedge i_ref_clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int at;
    int ratio;
    bit en;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge i_ref_clk) begin
    if (i_rst_n) begin
      if (o_done || o_err) begin
        check("done_err_exclusive", {31'd0, o_done & o_err}, 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, o_done, o_err}, 0);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_is_err", {31'd0, o_err}, {31'd0, mon_e.is_err});
          check("pulse_cycle", cyc, mon_e.at);
          check("pulse_ratio", {29'd0, o_div_ratio}, mon_e.ratio);
          check("pulse_clk_en", {31'd0, o_clk_en}, {31'd0, mon_e.en});
        end
      end else if (sb.size() > 0 && cyc > sb[0].at) begin
        mon_e = sb.pop_front();
        check("missed_pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  // Presents one request when ready; a is the accept edge number.
  task automatic issue(input int ratio, input bit en, input bit push, input int lat,
                       input bit is_err, input int exp_ratio, input bit exp_en,
                       output int a);
    int budget;
    exp_t e;
    budget = 0;
    @(negedge i_ref_clk);
    while (!o_req_ready && budget < 200) begin
      @(negedge i_ref_clk);
      budget++;
    end
    if (!o_req_ready) check("ready_timeout", {31'd0, o_req_ready}, 1);
    i_req_valid = 1'b1;
    i_req_ratio = 3'(ratio);
    i_req_en    = en;
    a = cyc + 1;
    if (push) begin
      e.is_err = is_err;
      e.at     = a + lat;
      e.ratio  = exp_ratio;
      e.en     = exp_en;
      sb.push_back(e);
    end
    @(posedge i_ref_clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 100) begin
      @(negedge i_ref_clk);
      budget++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge i_ref_clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ratio"}, {29'd0, o_div_ratio}, 2);
    check({tag, "_clk_en"}, {31'd0, o_clk_en}, 0);
    check({tag, "_ready"}, {31'd0, o_req_ready}, 1);
    check({tag, "_busy"}, {31'd0, o_busy}, 0);
    check({tag, "_done"}, {31'd0, o_done}, 0);
    check({tag, "_err"}, {31'd0, o_err}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    repeat (3) @(negedge i_ref_clk);
    check_reset_vals("reset");
    i_rst_n = 1'b1;
    @(negedge i_ref_clk);

    // disabled ratio 2 -> ratio 5 enabled: ratio at A+1, done at A+5
    issue(5, 1'b1, 1'b1, 5, 1'b0, 5, 1'b1, a);
    @(negedge i_ref_clk);
    @(negedge i_ref_clk);
    check("dis2en_ratio_at_A1", {29'd0, o_div_ratio}, 5);
    wait_drain();

    // enabled 5 -> 2: 2*5+2+4+1 = 17
    issue(2, 1'b1, 1'b1, 17, 1'b0, 2, 1'b1, a);
    wait_drain();

    // enabled 2 -> 5: clk_en falls at A, ratio at A+7, done at A+11
    issue(5, 1'b1, 1'b1, 11, 1'b0, 5, 1'b1, a);
    check("en2en_clk_en_at_A", {31'd0, o_clk_en}, 0);
    for (int k = 0; k < 11; k++) begin
      @(negedge i_ref_clk);
      check("en2en_ready_low", {31'd0, o_req_ready}, 0);
      if (k == 6) check("en2en_ratio_at_A6", {29'd0, o_div_ratio}, 2);
      if (k == 7) check("en2en_ratio_at_A7", {29'd0, o_div_ratio}, 5);
      if (k == 3) begin
        i_req_valid = 1'b1;
        i_req_ratio = 3'd3;
        i_req_en    = 1'b0;
      end
      if (k == 4) i_req_valid = 1'b0;
    end
    wait_drain();

    // enabled 5 -> 7: 17
    issue(7, 1'b1, 1'b1, 17, 1'b0, 7, 1'b1, a);
    wait_drain();

    // enabled 7 -> disabled: 2*7+2+1 = 17, ratio stays 7
    issue(7, 1'b0, 1'b1, 17, 1'b0, 7, 1'b0, a);
    wait_drain();
    // identical request: no-op, done at A+1
    issue(7, 1'b0, 1'b1, 1, 1'b0, 7, 1'b0, a);
    wait_drain();
    // disabled, new ratio, stay disabled: LOAD then done, ratio unchanged
    issue(3, 1'b0, 1'b1, 1, 1'b0, 7, 1'b0, a);
    wait_drain();

    // reach enabled ratio 2, then reset in the middle of a 2 -> 5 change
    issue(2, 1'b1, 1'b1, 5, 1'b0, 2, 1'b1, a);
    wait_drain();
    issue(5, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, a);
    while (cyc < a + 3) @(negedge i_ref_clk);
    i_rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (3) @(negedge i_ref_clk);
    i_rst_n = 1'b1;
    repeat (20) @(negedge i_ref_clk);
    check("midreset_no_done_pending", sb.size(), 0);
    issue(5, 1'b1, 1'b1, 5, 1'b0, 5, 1'b1, a);
    wait_drain();

    // ratio 1 enabled request from enabled ratio 5
`ifdef CLK_DIV_CTRL_RANGE_CHK_EN
    issue(1, 1'b1, 1'b1, 1, 1'b1, 5, 1'b1, a);
`else
    issue(1, 1'b1, 1'b1, 17, 1'b0, 1, 1'b1, a);
`endif
    wait_drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Sequencing controller for the integer clock divider (`ClkDiv`). It owns the divider's `i_clk_en` and `i_div_ratio` inputs and accepts ratio-change and enable/disable requests over a valid/ready handshake. It applies each change glitch-safely: gate the divider, drain for a ratio-dependent time, load the new ratio, settle, then re-enable. It sits between the system register/command block and the divider, in the divider's reference-clock domain.

## Interface
Parameters:
- `RATIO_W`, 3: width of the ratio bus.
- `DEF_RATIO`, 2: ratio driven out of reset.
- `DRAIN_EXTRA`, 2: extra drain cycles added to 2×current ratio.
- `SETTLE_CYCLES`, 4: cycles between ratio load and re-enable; must be ≥1.

Ports:
- `i_ref_clk` in 1: reference clock, the same clock as the divider.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req_valid` in 1: request valid.
- `i_req_ratio` in RATIO_W: requested divide ratio.
- `i_req_en` in 1: requested divider enable state.
- `o_req_ready` out 1: controller can accept a request. High only in IDLE.
- `o_div_ratio` out RATIO_W: to the divider's `i_div_ratio`. Registered.
- `o_clk_en` out 1: to the divider's `i_clk_en`. Registered.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_done` out 1: one-cycle pulse when a request completes.
- `o_err` out 1: one-cycle pulse when a request is rejected (see Configuration).

## Operation
- Reset values: `o_div_ratio`=DEF_RATIO, `o_clk_en`=0, `o_req_ready`=1, `o_busy`=0, `o_done`=0, `o_err`=0, state=IDLE, counter=0.
- Accept: a request is accepted on a rising edge where `i_req_valid` & `o_req_ready` are both high.
  - The requested ratio and enable are latched on that edge.
  - Valid while not ready is ignored; the requester holds valid until ready.
- States:
  - IDLE → (accept, no-op) IDLE. A no-op request has the same ratio and enable as current. `o_done` pulses the next cycle.
  - IDLE → (accept, `o_clk_en`=1) DRAIN. On the same edge: `o_clk_en`←0, counter←2×`o_div_ratio`+DRAIN_EXTRA−1.
  - IDLE → (accept, `o_clk_en`=0) LOAD. Drain is skipped.
  - DRAIN: counter decrements each cycle; at counter==0 → LOAD.
  - LOAD, `i_req_en` latched 1: `o_div_ratio`←latched ratio, counter←SETTLE_CYCLES−1 → SETTLE.
  - LOAD, `i_req_en` latched 0: `o_div_ratio` unchanged, `o_done` pulses → IDLE. `o_clk_en` stays 0.
  - SETTLE: counter decrements; at counter==0: `o_clk_en`←1, `o_done` pulses → IDLE.
- Counter width is RATIO_W+2 bits. 2×7+2=16 must not wrap.
- Reset mid-operation: all outputs return to reset values immediately. The in-flight request is dropped and no `o_done` is generated.
- `o_done` and `o_err` never assert in the same cycle.

## Timing
- Edges below are counted from the accept edge A. C is the current ratio, D is DRAIN_EXTRA, S is SETTLE_CYCLES.
- Enabled → new ratio, enabled:
  - `o_clk_en` falls at A.
  - `o_div_ratio` updates at A+2C+D+1.
  - `o_clk_en` rises and `o_done` pulses at A+2C+D+S+1.
  - `o_req_ready` is high in the cycle after that edge.
- Disabled → enabled: `o_div_ratio` updates at A+1; `o_clk_en` rises and `o_done` pulses at A+S+1.
- Enabled → disabled: `o_done` pulses at A+2C+D+1.
- No-op request: `o_done` pulses at A+1.
- Back-to-back: the next request can be accepted on the edge after `o_done` deasserts ready→IDLE, i.e. immediately when ready is seen high.

## Configuration
- Macro: `CLK_DIV_CTRL_RANGE_CHK_EN`.
- Defined: an accepted request with `i_req_en`=1 and `i_req_ratio`<2 is rejected.
  - `o_err` pulses at A+1.
  - State stays IDLE; `o_div_ratio` and `o_clk_en` are unchanged; no `o_done`.
- Undefined: no check is made. Ratios 0 and 1 are sequenced like any other value, and `o_err` is tied to 0.

## Test plan
Defaults apply (D=2, S=4) unless stated otherwise.
1. Reset: hold `i_rst_n`=0 → `o_div_ratio`=2, `o_clk_en`=0, `o_req_ready`=1, `o_busy`=0, `o_done`=0, `o_err`=0.
2. From the disabled state, request ratio 5 with en=1 at edge A → `o_div_ratio`=5 at A+1; `o_clk_en`=1 and `o_done`=1 at A+5.
3. From enabled ratio 2, request ratio 5 with en=1 at A → `o_clk_en`=0 at A, ratio=5 at A+7, `o_clk_en`=1 and `o_done` at A+11. Check that ready is low throughout and that `i_req_valid` pulses during busy are ignored.
4. From enabled ratio 7, request en=0 → `o_done` at A+17, ratio stays 7, `o_clk_en` stays 0. Repeat the identical request → `o_done` at A+1, with no drain.
5. Assert `i_rst_n`=0 at A+3 of scenario 3 → outputs return to reset values immediately and no `o_done` is generated. After reset release, a new request completes normally.
6. With `CLK_DIV_CTRL_RANGE_CHK_EN` defined, request ratio 1 with en=1 → `o_err` pulses at A+1 and ratio/enable are unchanged. With the macro undefined, the same request → ratio=1 and `o_done` at the normal latency.
